shot_controller: RTL and testbench
==================================

SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 Parameter SCREEN_W, default 640, SHALL be the horizontal out-of-bounds limit in pixels.
REQ-002 Parameter SCREEN_H, default 480, SHALL be the vertical out-of-bounds limit in pixels.
REQ-003 Parameter COOLDOWN_FRAMES, default 8, SHALL be the number of frame edges between the end of one shot and re-arm.
REQ-004 Parameter MAX_FLIGHT_FRAMES, default 255, SHALL be the flight timeout in frame edges.
REQ-005 Clk  in  1  system clock, 50 MHz; reset Reset, synchronous, active-high; clock Clk.
REQ-006 Reset  in  1  synchronous active-high reset.
REQ-007 frame_clk  in  1  frame strobe, ~60 Hz, Clk-synchronous.
REQ-008 leftButton  in  1  raw mouse left button, asynchronous.
REQ-009 x_vector, y_vector  in  9 each  signed aim unit vector, scaled by 256, from the aim logic.
REQ-010 ballX, ballY  in  10 each  current shot-ball position.
REQ-011 hit  in  1  chain collision flag for the shot ball.
REQ-012 launch_reset  out  1  drives the shot-ball Reset.
REQ-013 launch_x_vector, launch_y_vector  out  9 each  latched vectors fed to the shot ball.
REQ-014 shot_active  out  1  shot ball visible/in flight.
REQ-015 shot_done  out  1  one-Clk pulse when a shot ends.
REQ-016 shot_hit  out  1  qualifies shot_done: 1 = hit, 0 = miss/timeout.
REQ-017 color_current, color_next  out  2 each  loaded-ball and preview-ball colours.

Function
REQ-018 leftButton SHALL pass through a 2-flop synchroniser, then a registered rising-edge detector, giving a 1-cycle click pulse.
REQ-019 frame_clk SHALL pass through a registered rising-edge detector, giving a 1-cycle frame pulse.
REQ-020 FSM states SHALL be IDLE, ARM, FLY and COOLDOWN.
REQ-021 IDLE->ARM SHALL occur on a click pulse; on that edge launch_x_vector/launch_y_vector SHALL latch x_vector/y_vector and hold until the next ARM.
REQ-022 ARM SHALL last exactly one Clk, then go to FLY.
REQ-023 launch_reset SHALL be 1 only while in ARM (Moore).
REQ-024 shot_active SHALL be 1 in ARM and FLY.
REQ-025 In FLY, an 8-bit flight counter SHALL increment per frame pulse and clear on entry to FLY.
REQ-026 FLY->COOLDOWN SHALL occur, in priority order:
  - (a) hit=1 on any cycle: shot_hit=1.
  - (b) frame pulse with ballX>=SCREEN_W or ballY>=SCREEN_H: miss. Underflow wraps to >=SCREEN_W/H, so no separate negative check is needed.
  - (c) frame pulse with counter==MAX_FLIGHT_FRAMES-1: timeout, shot_hit=0.
REQ-027 shot_done SHALL pulse for the one Clk of the FLY->COOLDOWN transition cycle (registered, visible the cycle after); shot_hit SHALL hold its value until the next shot_done.
REQ-028 COOLDOWN SHALL count COOLDOWN_FRAMES frame pulses, then return to IDLE; COOLDOWN_FRAMES=0 SHALL return to IDLE on the next Clk.
REQ-029 Clicks outside IDLE SHALL be dropped, not queued.
REQ-030 A click pulse coincident with the frame pulse in IDLE SHALL still arm.

Reset
REQ-031 Reset SHALL force:
  - state IDLE, all counters 0;
  - launch_reset=0, shot_active=0, shot_done=0, shot_hit=0;
  - launch vectors 0;
  - color_current=0, color_next=1, LFSR=4'b1001;
  - synchroniser and edge flops 0.
REQ-032 Reset mid-FLY SHALL abort the shot without a shot_done pulse.

Configuration
REQ-033 With SHOT_COLOR_QUEUE_EN defined:
  - a 4-bit maximal LFSR (x^4+x^3+1) SHALL step once per IDLE->ARM;
  - on that edge color_current<=color_next and color_next<=LFSR[1:0] (new state).
REQ-034 Without SHOT_COLOR_QUEUE_EN, color_current and color_next SHALL be constant 0 and no LFSR SHALL be instantiated.

Structure
REQ-035 Package zuma_pkg SHALL hold:
  - the shot_state_t enum (IDLE, ARM, FLY, COOLDOWN);
  - the ball_color_t 2-bit typedef;
  - the LFSR seed constant;
  - screen-size constants.
REQ-036 A sub-module rise_detect (optional 2-flop synchroniser, parameter SYNC) SHALL implement REQ-018 and REQ-019.

Verification
REQ-037 Click in IDLE with x_vector=9'd256, y_vector=0 -> launch_reset high exactly 1 Clk; launch_x_vector=256; shot_active=1 from ARM onward.
REQ-038 In FLY, drive ballX=640 on a frame pulse -> shot_done pulse with shot_hit=0; IDLE reached after 8 further frame pulses.
REQ-039 In FLY, assert hit with ballY=500 on the same frame pulse -> shot_hit=1 (hit wins).
REQ-040 In FLY, hold the ball in bounds, no hit -> timeout after 255 frame pulses, shot_hit=0.
REQ-041 Click during FLY and during COOLDOWN -> no second launch_reset; click after return to IDLE -> launch occurs.
REQ-042 With SHOT_COLOR_QUEUE_EN, three launches from reset -> color_current sequence 1, then successive LFSR[1:0] values; Reset asserted mid-FLY -> no shot_done, outputs at reset values next cycle.

Source files
------------

// File: rtl/zuma_pkg.sv
// -----------------------------------------------------------------------------
// zuma_pkg
// Shared types and constants for the shot controller slice.
//   shot_state_t     : launcher FSM states
//   ball_color_t     : 2-bit ball colour code
//   LFSR_SEED        : reset value of the colour-queue LFSR
//   SCREEN_*_DEFAULT : default out-of-bounds limits in pixels
//   lfsr_step        : one step of the x^4+x^3+1 Fibonacci LFSR
// -----------------------------------------------------------------------------
package zuma_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    FLY      = 2'd2,
    COOLDOWN = 2'd3
  } shot_state_t;

  typedef logic [1:0] ball_color_t;

  localparam logic [3:0] LFSR_SEED = 4'b1001;

  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  // Shift left, feedback from the x^4 and x^3 taps; period 15 from any
  // non-zero seed.
  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

endpackage

// File: rtl/shot_controller_if.sv
// -----------------------------------------------------------------------------
// shot_controller_if
// Bundles the aim inputs, shot-ball feedback and launch/status outputs of the
// shot controller.
//   master : the shot controller (consumes aim/ball, drives launch/status)
//   slave  : the aim logic / shot ball side
// Vectors are carried as raw 9-bit patterns (two's complement, scaled by 256);
// the controller only latches them, it never does arithmetic on them.
// -----------------------------------------------------------------------------
interface shot_controller_if;
  import zuma_pkg::*;

  logic [8:0]  x_vector;
  logic [8:0]  y_vector;
  logic [9:0]  ballX;
  logic [9:0]  ballY;
  logic        hit;
  logic        launch_reset;
  logic [8:0]  launch_x_vector;
  logic [8:0]  launch_y_vector;
  logic        shot_active;
  logic        shot_done;
  logic        shot_hit;
  ball_color_t color_current;
  ball_color_t color_next;

  modport master (
    input  x_vector, y_vector, ballX, ballY, hit,
    output launch_reset, launch_x_vector, launch_y_vector,
           shot_active, shot_done, shot_hit, color_current, color_next
  );

  modport slave (
    output x_vector, y_vector, ballX, ballY, hit,
    input  launch_reset, launch_x_vector, launch_y_vector,
           shot_active, shot_done, shot_hit, color_current, color_next
  );

endinterface

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector with an optional 2-flop synchroniser.
//   Clk, Reset : clock, synchronous active-high reset
//   din        : level input (asynchronous when SYNC=1)
//   pulse      : one-Clk pulse per rising edge of din
// Latency din->pulse: 1 edge (SYNC=0) or 3 edges (SYNC=1).
// -----------------------------------------------------------------------------
module rise_detect #(
  parameter bit SYNC = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic pulse
);

  logic level;
  logic prev_reg;
  logic pulse_reg;

  generate
    if (SYNC) begin : g_sync
      logic sync1_reg;
      logic sync2_reg;
      always_ff @(posedge Clk) begin
        if (Reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= din;
          sync2_reg <= sync1_reg;
        end
      end
      assign level = sync2_reg;
    end else begin : g_direct
      assign level = din;
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      prev_reg  <= level;
      pulse_reg <= level & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/shot_controller.sv
// -----------------------------------------------------------------------------
// shot_controller
// Launch sequencer for the shot ball: click -> one-cycle ARM (shot-ball reset,
// vectors latched) -> FLY until hit / out of bounds / timeout -> COOLDOWN for
// a number of frames -> IDLE. Clicks outside IDLE are dropped.
//   Clk, Reset : 50 MHz clock, synchronous active-high reset
//   frame_clk  : ~60 Hz frame strobe, Clk-synchronous
//   leftButton : raw mouse button, asynchronous
//   sif        : aim vectors, ball position/hit in; launch/status/colours out
// Optional feature macro: SHOT_COLOR_QUEUE_EN -- enables the LFSR-driven
// current/next ball colour queue; otherwise both colours are constant 0.
// -----------------------------------------------------------------------------
module shot_controller
  import zuma_pkg::*;
#(
  parameter int SCREEN_W          = SCREEN_W_DEFAULT,
  parameter int SCREEN_H          = SCREEN_H_DEFAULT,
  parameter int COOLDOWN_FRAMES   = 8,
  parameter int MAX_FLIGHT_FRAMES = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              leftButton,
  shot_controller_if.master sif
);

  localparam logic [7:0] FLIGHT_LAST = 8'(MAX_FLIGHT_FRAMES - 1);
  localparam logic [7:0] COOL_LAST   = 8'(COOLDOWN_FRAMES - 1);

  logic click_pulse;
  logic frame_pulse;

  rise_detect #(.SYNC(1'b1)) u_click (
    .Clk   (Clk),
    .Reset (Reset),
    .din   (leftButton),
    .pulse (click_pulse)
  );

  rise_detect #(.SYNC(1'b0)) u_frame (
    .Clk   (Clk),
    .Reset (Reset),
    .din   (frame_clk),
    .pulse (frame_pulse)
  );

  shot_state_t state_reg;
  logic [7:0]  flight_cnt_reg;
  logic [7:0]  cool_cnt_reg;
  logic        launch_reset_reg;
  logic        shot_active_reg;
  logic        shot_done_reg;
  logic        shot_hit_reg;
  logic [8:0]  launch_x_reg;
  logic [8:0]  launch_y_reg;

  // A ball left of / above the screen wraps to a large unsigned value, so a
  // single upper-bound compare covers both sides.
  logic out_of_bounds;
  logic shot_end;
  logic cool_done;

  assign out_of_bounds = (int'(sif.ballX) >= SCREEN_W) || (int'(sif.ballY) >= SCREEN_H);
  // Hit is checked every cycle; bounds and timeout only on frame pulses.
  assign shot_end      = sif.hit ||
                         (frame_pulse && (out_of_bounds || (flight_cnt_reg == FLIGHT_LAST)));
  assign cool_done     = (COOLDOWN_FRAMES == 0) ||
                         (frame_pulse && (cool_cnt_reg == COOL_LAST));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg        <= IDLE;
      flight_cnt_reg   <= '0;
      cool_cnt_reg     <= '0;
      launch_reset_reg <= 1'b0;
      shot_active_reg  <= 1'b0;
      shot_done_reg    <= 1'b0;
      shot_hit_reg     <= 1'b0;
      launch_x_reg     <= '0;
      launch_y_reg     <= '0;
    end else begin
      shot_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (click_pulse) begin
            state_reg        <= ARM;
            launch_reset_reg <= 1'b1;
            shot_active_reg  <= 1'b1;
            launch_x_reg     <= sif.x_vector;
            launch_y_reg     <= sif.y_vector;
          end
        end
        ARM: begin
          state_reg        <= FLY;
          launch_reset_reg <= 1'b0;
          flight_cnt_reg   <= '0;
        end
        FLY: begin
          if (shot_end) begin
            state_reg       <= COOLDOWN;
            shot_active_reg <= 1'b0;
            shot_done_reg   <= 1'b1;
            shot_hit_reg    <= sif.hit;
            cool_cnt_reg    <= '0;
          end else if (frame_pulse) begin
            flight_cnt_reg <= flight_cnt_reg + 8'd1;
          end
        end
        COOLDOWN: begin
          if (cool_done) begin
            state_reg <= IDLE;
          end else if (frame_pulse) begin
            cool_cnt_reg <= cool_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sif.launch_reset    = launch_reset_reg;
  assign sif.shot_active     = shot_active_reg;
  assign sif.shot_done       = shot_done_reg;
  assign sif.shot_hit        = shot_hit_reg;
  assign sif.launch_x_vector = launch_x_reg;
  assign sif.launch_y_vector = launch_y_reg;

`ifdef SHOT_COLOR_QUEUE_EN
  logic [3:0]  lfsr_reg;
  logic [3:0]  lfsr_next;
  ball_color_t color_cur_reg;
  ball_color_t color_next_reg;

  assign lfsr_next = lfsr_step(lfsr_reg);

  // The queue advances only on a launch; the preview takes the freshly
  // stepped LFSR value, not the old one.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_reg       <= LFSR_SEED;
      color_cur_reg  <= 2'd0;
      color_next_reg <= 2'd1;
    end else if ((state_reg == IDLE) && click_pulse) begin
      lfsr_reg       <= lfsr_next;
      color_cur_reg  <= color_next_reg;
      color_next_reg <= lfsr_next[1:0];
    end
  end

  assign sif.color_current = color_cur_reg;
  assign sif.color_next    = color_next_reg;
`else
  assign sif.color_current = '0;
  assign sif.color_next    = '0;
`endif

endmodule

// File: tb/tb_shot_controller.sv
`timescale 1ns/1ps
module tb_shot_controller;

  localparam int W        = 640;
  localparam int H        = 480;
  localparam int CD       = 8;
  localparam int MAXF     = 255;
`ifdef SHOT_COLOR_QUEUE_EN
  localparam bit COLOR_EN = 1'b1;
`else
  localparam bit COLOR_EN = 1'b0;
`endif

  logic Clk        = 1'b0;
  logic Reset      = 1'b1;
  logic frame_clk  = 1'b0;
  logic leftButton = 1'b0;

  shot_controller_if sif();

  shot_controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .leftButton (leftButton),
    .sif        (sif)
  );

  always #10 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 arming, 2 flying, 3 cooling down.
  int m_mode = 0;
  int m_flight = 0;
  int m_cool_left = 0;
  int m_done = 0;
  int m_hit = 0;
  int m_lx = 0;
  int m_ly = 0;
  int m_cur = 0;
  int m_next = 0;
  int m_lfsr = 9;
  // Input samples per edge, [0] = this edge. A click takes effect 3 edges
  // after the button rises (2 sync + edge register); a frame 1 edge after.
  bit bh[0:4];
  bit fh[0:2];

  function automatic int lfsr_next(input int l);
    return ((l << 1) | (((l >> 3) ^ (l >> 2)) & 1)) & 15;
  endfunction

  initial begin
    for (int k = 0; k < 5; k++) bh[k] = 1'b0;
    for (int k = 0; k < 3; k++) fh[k] = 1'b0;
    forever begin
      bit click, frm, oob;
      @(posedge Clk);
      for (int k = 4; k > 0; k--) bh[k] = bh[k-1];
      for (int k = 2; k > 0; k--) fh[k] = fh[k-1];
      bh[0] = leftButton;
      fh[0] = frame_clk;
      if (Reset) begin
        for (int k = 0; k < 5; k++) bh[k] = 1'b0;
        for (int k = 0; k < 3; k++) fh[k] = 1'b0;
        m_mode = 0; m_flight = 0; m_cool_left = 0;
        m_done = 0; m_hit = 0; m_lx = 0; m_ly = 0;
        m_cur = 0; m_next = COLOR_EN ? 1 : 0; m_lfsr = 9;
      end else begin
        click  = bh[3] && !bh[4];
        frm    = fh[1] && !fh[2];
        m_done = 0;
        case (m_mode)
          0: if (click) begin
            m_mode = 1;
            m_lx = int'(sif.x_vector);
            m_ly = int'(sif.y_vector);
            if (COLOR_EN) begin
              m_lfsr = lfsr_next(m_lfsr);
              m_cur  = m_next;
              m_next = m_lfsr % 4;
            end
          end
          1: begin
            m_mode = 2;
            m_flight = 0;
          end
          2: begin
            oob = (int'(sif.ballX) >= W) || (int'(sif.ballY) >= H);
            if (sif.hit || (frm && (oob || m_flight + 1 == MAXF))) begin
              m_mode = 3; m_done = 1; m_hit = sif.hit ? 1 : 0; m_cool_left = CD;
            end else if (frm) begin
              m_flight++;
            end
          end
          default: begin
            if (m_cool_left == 0) m_mode = 0;
            else if (frm) begin
              m_cool_left--;
              if (m_cool_left == 0) m_mode = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  bit done_seen = 1'b0;
  int lr_cycles = 0;

  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      check("launch_reset", int'(sif.launch_reset), int'(m_mode == 1));
      check("shot_active", int'(sif.shot_active), int'(m_mode == 1 || m_mode == 2));
      check("shot_done", int'(sif.shot_done), m_done);
      check("shot_hit", int'(sif.shot_hit), m_hit);
      check("launch_x", int'(sif.launch_x_vector), m_lx);
      check("launch_y", int'(sif.launch_y_vector), m_ly);
      check("color_current", int'(sif.color_current), m_cur);
      check("color_next", int'(sif.color_next), m_next);
    end
    if (sif.shot_done) done_seen = 1'b1;
    if (sif.launch_reset) lr_cycles++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    cyc(1);
    frame_clk = 1'b0;
    cyc(2);
  endtask

  task automatic click();
    leftButton = 1'b1;
    cyc(3);
    leftButton = 1'b0;
    cyc(2);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_pulse();
  endtask

  initial begin
    int lr0;
    int n;
    sif.x_vector = '0;
    sif.y_vector = '0;
    sif.ballX    = 10'd100;
    sif.ballY    = 10'd100;
    sif.hit      = 1'b0;
    Reset = 1'b1;
    cyc(3);
    Reset  = 1'b0;
    chk_en = 1'b1;

    check("rst_launch_reset", int'(sif.launch_reset), 0);
    check("rst_shot_active", int'(sif.shot_active), 0);
    check("rst_shot_done", int'(sif.shot_done), 0);
    check("rst_launch_x", int'(sif.launch_x_vector), 0);
    check("rst_color_next", int'(sif.color_next), COLOR_EN ? 1 : 0);

    // Launch 1: vector latch, single-cycle launch_reset.
    lr0 = lr_cycles;
    sif.x_vector = 9'd256;
    sif.y_vector = 9'd0;
    click();
    cyc(3);
    $display("[TB] launch 1 x=%0d lr_cycles=%0d", sif.launch_x_vector, lr_cycles - lr0);
    check("arm_lr_cycles", lr_cycles - lr0, 1);
    check("arm_launch_x", int'(sif.launch_x_vector), 256);
    check("arm_shot_active", int'(sif.shot_active), 1);
    check("arm1_color_cur", int'(sif.color_current), COLOR_EN ? 1 : 0);
    check("arm1_color_next", int'(sif.color_next), COLOR_EN ? 3 : 0);

    // Miss off the right edge, then cooldown of 8 frames.
    done_seen = 1'b0;
    sif.ballX = 10'd640;
    frame_pulse();
    sif.ballX = 10'd100;
    cyc(2);
    $display("[TB] miss done=%0d hit=%0d", done_seen, sif.shot_hit);
    check("miss_done", int'(done_seen), 1);
    check("miss_hit", int'(sif.shot_hit), 0);
    frames(CD - 1);
    lr0 = lr_cycles;
    click();
    cyc(3);
    check("cooldown_click_dropped", lr_cycles - lr0, 0);
    frames(1);
    lr0 = lr_cycles;
    sif.x_vector = 9'h1F0;
    click();
    cyc(3);
    $display("[TB] launch 2 after cooldown lr_cycles=%0d", lr_cycles - lr0);
    check("idle_click_launch", lr_cycles - lr0, 1);
    check("arm2_color_cur", int'(sif.color_current), COLOR_EN ? 3 : 0);

    // Hit together with an out-of-bounds Y on the same frame: hit wins.
    done_seen = 1'b0;
    sif.hit   = 1'b1;
    sif.ballY = 10'd500;
    frame_pulse();
    sif.hit   = 1'b0;
    sif.ballY = 10'd100;
    cyc(2);
    $display("[TB] hit done=%0d hit=%0d", done_seen, sif.shot_hit);
    check("hit_done", int'(done_seen), 1);
    check("hit_wins", int'(sif.shot_hit), 1);

    // Launch 3, click during flight is dropped, then timeout.
    frames(CD);
    click();
    cyc(3);
    check("arm3_color_cur", int'(sif.color_current), COLOR_EN ? 2 : 0);
    check("arm3_color_next", int'(sif.color_next), COLOR_EN ? 1 : 0);
    lr0 = lr_cycles;
    click();
    cyc(2);
    check("fly_click_dropped", lr_cycles - lr0, 0);
    done_seen = 1'b0;
    n = 0;
    while (!done_seen && n < MAXF + 20) begin
      frame_pulse();
      n++;
    end
    $display("[TB] timeout after %0d frames hit=%0d", n, sif.shot_hit);
    check("timeout_frames", n, 255);
    check("timeout_hit", int'(sif.shot_hit), 0);

    // Reset mid-flight: no shot_done, outputs back to reset values.
    frames(CD);
    sif.x_vector = 9'd77;
    click();
    cyc(2);
    done_seen = 1'b0;
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    check("midrst_shot_active", int'(sif.shot_active), 0);
    check("midrst_launch_x", int'(sif.launch_x_vector), 0);
    check("midrst_color_cur", int'(sif.color_current), 0);
    cyc(5);
    $display("[TB] reset mid-flight done_seen=%0d", done_seen);
    check("midrst_no_done", int'(done_seen), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) leftButton = ~leftButton;
      frame_clk    = ($urandom_range(0, 3) == 0);
      sif.hit      = ($urandom_range(0, 40) == 0);
      sif.ballX    = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(640, 1023))
                                                 : 10'($urandom_range(0, 639));
      sif.ballY    = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(480, 1023))
                                                 : 10'($urandom_range(0, 479));
      sif.x_vector = 9'($urandom);
      sif.y_vector = 9'($urandom);
      Reset        = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    Reset = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
